volcado_memoria: RTL and testbench
==================================

# volcado_memoria

Sequential reader for the BIP I data memory, used by the debug unit to dump memory contents to the host. On a start pulse it reads a programmable run of words, starting at a base address. It drives the memory's address and write-enable inputs and captures each 16-bit read word. Each word is emitted as two bytes, low byte first, over a valid/ready byte stream that feeds the UART transmitter. The debug top-level multiplexes `o_addr`/`o_wea` onto the memory only while `o_busy` is high.

## Interface
- `DATA_WIDTH`, 16, memory word width; must be exactly 2×`BYTE_WIDTH`
- `ADDR_WIDTH`, 10, memory address width (1024-word memory)
- `BYTE_WIDTH`, 8, stream byte width
- `i_clk` in 1: single clock; all state updates on rising edge
- `i_rst_n` in 1: reset; asynchronous, active-low
- `i_start` in 1: start request, sampled only in IDLE
- `i_base` in `ADDR_WIDTH`: first address, latched at start
- `i_count` in `ADDR_WIDTH`+1: number of words, latched at start; range 0..2^`ADDR_WIDTH`
- `o_addr` out `ADDR_WIDTH`: memory address
- `o_wea` out 1: memory write enable; constant 0
- `i_mem_data` in `DATA_WIDTH`: memory read data
- `o_byte` out `BYTE_WIDTH`: stream data
- `o_byte_valid` out 1: stream valid
- `i_byte_ready` in 1: stream ready from the UART transmitter
- `o_busy` out 1: high in every state except IDLE
- `o_done` out 1: one-cycle pulse at the end of a dump

## Operation
- States: IDLE, READ, SEND_LO, SEND_HI, DONE (+ SEND_CHK, see Configuration).
- IDLE:
  - On `i_start`=1 with `i_count`≠0: latch base and count; go to READ.
  - On `i_start`=1 with `i_count`=0: go to DONE.
  - `i_start` is ignored in all other states.
- READ:
  - `o_addr` holds the current address.
  - The memory reads on the falling edge, so `i_mem_data` is valid at the next rising edge.
  - At that edge the word is captured into an internal register; go to SEND_LO.
- SEND_LO:
  - `o_byte_valid`=1, `o_byte`=word[7:0].
  - A transfer happens on a rising edge with `o_byte_valid` & `i_byte_ready`; on transfer go to SEND_HI.
- SEND_HI:
  - Same handshake with `o_byte`=word[15:8].
  - On transfer: decrement the remaining count and increment the address.
  - Go to READ if words remain, otherwise go to DONE (or SEND_CHK).
- DONE: `o_done`=1 for exactly one cycle; return to IDLE.
- Handshake rules:
  - While waiting for ready, `o_byte` and `o_byte_valid` hold stable.
  - Valid never drops before the transfer completes.
- Address arithmetic: modulo 2^`ADDR_WIDTH`. Base 1023 with count 2 reads 1023, then 0.
- Maximum count: `i_count`=1024 dumps the whole memory.
- `o_wea` is 0 at all times, including during reset.

## Timing
- Reset values: `o_addr`=0, `o_wea`=0, `o_byte`=0, `o_byte_valid`=0, `o_busy`=0, `o_done`=0, state IDLE, internal word/count/checksum registers 0.
- Reset asserted mid-dump: immediately aborts to IDLE with reset values. No `o_done` pulse is produced.
- Start sampled at edge E:
  - `o_busy`=1 and `o_addr`=base after E.
  - First byte valid after E+1.
- With ready held high, each word takes 3 cycles (READ, SEND_LO, SEND_HI).
- An N-word dump with constant ready: `o_done` is high in cycle E+3N+1.
- Count 0: `o_done` is high in the cycle after E, and no bytes are emitted.
- `o_busy` falls in the same cycle that `o_done` deasserts, i.e. on the return to IDLE.

## Configuration
- Macro: `VOLCADO_CHECKSUM_EN`.
- Defined:
  - After the last SEND_HI, state SEND_CHK emits one extra byte: the XOR of all bytes sent in this dump.
  - SEND_CHK uses the same handshake as the data bytes, then goes to DONE.
  - The checksum register clears at start.
  - Count 0 still goes straight to DONE, with no checksum byte.
- Not defined:
  - SEND_CHK and the checksum register do not exist.
  - SEND_HI goes directly to DONE.
  - Timing is exactly as in Timing.

## Test plan
- Memory with no init file (word i = i), base 5, count 2, ready always 1:
  - Bytes 05,00,06,00.
  - `o_done` at E+7.
  - With macro, an extra byte 03 follows.
- Ready toggling 1,0,0,1 during SEND_LO: `o_byte` stays 05 and valid stays high through the stalled cycles; exactly one transfer of 05.
- Base 1023, count 2: `o_addr` sequence 1023 then 0; bytes FF,03,00,00.
- Count 0: no valid asserted; `o_done` pulse one cycle after start; `o_busy` high for 1 cycle.
- `i_rst_n` low during the second word: outputs return to reset values asynchronously; no `o_done`; a new start after reset dumps correctly from its own base.
- `i_start` pulsed while busy: ignored; the byte sequence is identical to an undisturbed run; `o_wea` never 1.

Source files
------------

// File: rtl/volcado_memoria_if.sv
// Dump-unit bus: start/config, memory port and byte stream.
// slave = dump engine, master = debug top / memory / UART side.
interface volcado_memoria_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
);
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_base;
    logic [ADDR_WIDTH:0]   i_count;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic                  o_wea;
    logic [DATA_WIDTH-1:0] i_mem_data;
    logic [BYTE_WIDTH-1:0] o_byte;
    logic                  o_byte_valid;
    logic                  i_byte_ready;
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_start,
        input  i_base,
        input  i_count,
        output o_addr,
        output o_wea,
        input  i_mem_data,
        output o_byte,
        output o_byte_valid,
        input  i_byte_ready,
        output o_busy,
        output o_done
    );

    modport master (
        output i_start,
        output i_base,
        output i_count,
        input  o_addr,
        input  o_wea,
        output i_mem_data,
        input  o_byte,
        input  o_byte_valid,
        output i_byte_ready,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/volcado_memoria.sv
// Sequential BIP I data-memory dumper: words out as lo/hi byte stream.
// Optional trailing XOR checksum byte with VOLCADO_CHECKSUM_EN.
module volcado_memoria #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    volcado_memoria_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LO,
        S_HI,
        S_DONE
`ifdef VOLCADO_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t                state;
    state_t                nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   cnt_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [BYTE_WIDTH-1:0] byte_d;
    logic                  valid_d;
    logic                  xfer;
    logic                  last;
`ifdef VOLCADO_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] chk_q;
`endif

    assign xfer = valid_d & bus.i_byte_ready;
    assign last = (cnt_q == (ADDR_WIDTH+1)'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= nxt;
    end

    always_comb begin
        nxt     = state;
        valid_d = 1'b0;
        byte_d  = '0;
        unique case (state)
            S_IDLE: begin
                if (bus.i_start)
                    nxt = (bus.i_count == '0) ? S_DONE : S_READ;
            end
            S_READ: nxt = S_LO;
            S_LO: begin
                valid_d = 1'b1;
                byte_d  = word_q[BYTE_WIDTH-1:0];
                if (bus.i_byte_ready) nxt = S_HI;
            end
            S_HI: begin
                valid_d = 1'b1;
                byte_d  = word_q[DATA_WIDTH-1:BYTE_WIDTH];
                if (bus.i_byte_ready) begin
`ifdef VOLCADO_CHECKSUM_EN
                    nxt = last ? S_CHK : S_READ;
`else
                    nxt = last ? S_DONE : S_READ;
`endif
                end
            end
`ifdef VOLCADO_CHECKSUM_EN
            S_CHK: begin
                valid_d = 1'b1;
                byte_d  = chk_q;
                if (bus.i_byte_ready) nxt = S_DONE;
            end
`endif
            S_DONE: nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q <= '0;
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            if (state == S_IDLE && bus.i_start) begin
                addr_q <= bus.i_base;
                cnt_q  <= bus.i_count;
            end
            if (state == S_READ) word_q <= bus.i_mem_data;
            if (state == S_HI && xfer) begin
                cnt_q  <= cnt_q - (ADDR_WIDTH+1)'(1);
                addr_q <= addr_q + ADDR_WIDTH'(1);
            end
        end
    end

`ifdef VOLCADO_CHECKSUM_EN
    // Running XOR of every data byte accepted in this dump.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            chk_q <= '0;
        else if (state == S_IDLE && bus.i_start)
            chk_q <= '0;
        else if ((state == S_LO || state == S_HI) && xfer)
            chk_q <= chk_q ^ byte_d;
    end
`endif

    assign bus.o_addr       = addr_q;
    assign bus.o_wea        = 1'b0;
    assign bus.o_byte       = byte_d;
    assign bus.o_byte_valid = valid_d;
    assign bus.o_busy       = (state != S_IDLE);
    assign bus.o_done       = (state == S_DONE);
endmodule

// File: tb/tb_volcado_memoria.sv
// Randomized bench for volcado_memoria against a byte-list model.
// Memory model reads on the falling edge like the BIP I block RAM.
module tb_volcado_memoria;
    logic i_clk;
    logic i_rst_n;

    volcado_memoria_if #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .BYTE_WIDTH(8)) bus ();

    volcado_memoria #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .BYTE_WIDTH(8)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

`ifdef VOLCADO_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic [15:0] mem [1024];
    logic [7:0]  obs [$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt, done_cyc, busy_cnt, valid_cnt, viol, wea_seen;
    bit pend;
    logic [7:0] pend_byte;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    always @(negedge i_clk) bus.i_mem_data <= mem[bus.o_addr];

    always @(negedge i_clk) begin
        if (bus.o_wea !== 1'b0) wea_seen++;
        if (!i_rst_n) begin
            pend = 1'b0;
        end else begin
            if (bus.o_busy) busy_cnt++;
            if (bus.o_byte_valid) valid_cnt++;
            if (bus.o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (pend && (!bus.o_byte_valid || bus.o_byte !== pend_byte))
                viol++;
            if (bus.o_byte_valid && bus.i_byte_ready)
                obs.push_back(bus.o_byte);
            pend      = bus.o_byte_valid && !bus.i_byte_ready;
            pend_byte = bus.o_byte;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_dump(input logic [9:0] base, input int cnt,
                            input int mode, input bit poke);
        logic [7:0] exp_q [$];
        logic [15:0] w;
        logic [7:0] x;
        int e, k, n;
        bit to;
        x = 8'h00;
        for (int i = 0; i < cnt; i++) begin
            w = mem[(int'(base) + i) % 1024];
            exp_q.push_back(w[7:0]);
            exp_q.push_back(w[15:8]);
            x = x ^ w[7:0] ^ w[15:8];
        end
        if (CHK && cnt > 0) exp_q.push_back(x);
        obs.delete();
        done_cnt = 0; busy_cnt = 0; valid_cnt = 0; viol = 0;
        @(posedge i_clk); #1;
        bus.i_start      = 1'b1;
        bus.i_base       = base;
        bus.i_count      = 11'(cnt);
        bus.i_byte_ready = 1'b1;
        @(negedge i_clk);
        e = cyc + 1;
        @(posedge i_clk); #1;
        k = 0;
        to = 1'b0;
        while (done_cnt == 0 && !to) begin
            bus.i_start = poke && (k == 3);
            bus.i_base  = 10'($urandom);
            bus.i_count = 11'($urandom);
            case (mode)
                0: bus.i_byte_ready = 1'b1;
                1: bus.i_byte_ready = 1'($urandom_range(0, 1));
                default: bus.i_byte_ready = (k % 4 == 0) || (k % 4 == 3);
            endcase
            @(posedge i_clk); #1;
            k++;
            if (k > 12 * cnt + 20) to = 1'b1;
        end
        bus.i_start = 1'b0;
        @(negedge i_clk); #1;
        check("timeout", 32'(to), 32'd0);
        check("n_bytes", 32'(obs.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            check("byte", 32'(obs[i]), 32'(exp_q[i]));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("stable", 32'(viol), 32'd0);
        if (mode == 0) begin
            n = 3 * cnt + ((CHK && cnt > 0) ? 1 : 0);
            check("done_time", 32'(done_cyc - e), 32'(n));
            check("busy_cycles", 32'(busy_cnt), 32'(n + 1));
        end
        if (cnt == 0) check("no_valid", 32'(valid_cnt), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_addr"},  32'(bus.o_addr), 32'd0);
        check({tag, "_byte"},  32'(bus.o_byte), 32'd0);
        check({tag, "_valid"}, 32'(bus.o_byte_valid), 32'd0);
        check({tag, "_busy"},  32'(bus.o_busy), 32'd0);
        check({tag, "_done"},  32'(bus.o_done), 32'd0);
        check({tag, "_wea"},   32'(bus.o_wea), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        wea_seen = 0;
        pend = 1'b0;
        i_rst_n = 1'b0;
        bus.i_start = 1'b0;
        bus.i_base = '0;
        bus.i_count = '0;
        bus.i_byte_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check_reset_vals("rst");
        #3 i_rst_n = 1'b1;

        run_dump(10'd5, 2, 0, 1'b0);
        run_dump(10'd5, 2, 2, 1'b0);
        run_dump(10'd1023, 2, 0, 1'b0);
        run_dump(10'd77, 0, 0, 1'b0);
        run_dump(10'd40, 3, 0, 1'b1);

        done_cnt = 0;
        @(posedge i_clk); #1;
        bus.i_start = 1'b1;
        bus.i_base  = 10'd200;
        bus.i_count = 11'd6;
        @(posedge i_clk); #1;
        bus.i_start = 1'b0;
        repeat (5) @(posedge i_clk);
        #3 i_rst_n = 1'b0;
        #1 check_reset_vals("abort");
        repeat (3) @(posedge i_clk);
        #3 i_rst_n = 1'b1;
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_dump(10'd300, 2, 0, 1'b0);

        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        for (int r = 0; r < 8; r++)
            run_dump(10'($urandom), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        run_dump(10'($urandom), 1024, 0, 1'b0);

        check("wea_never", 32'(wea_seen), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
